level_store: RTL and testbench
==============================

LEVEL_STORE -- requirements
Module: level_store

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and rst.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst  input  1  asynchronous active-low reset.
REQ-004 Port: address  input  3  user entry index for the read and write paths.
REQ-005 Port: level_in  input  3  level value to store; driven by the level controller's level_o.
REQ-006 Port: wren  input  1  write request, sampled at every rising edge.
REQ-007 Port: clear_req  input  1  request to wipe all eight entries.
REQ-008 Port: level_out  output  3  registered read data; feeds the level controller's level_i.
REQ-009 Port: wr_ack  output  1  one-cycle pulse confirming an accepted write.
REQ-010 Port: busy  output  1  high while a clear sweep is in progress.

Function
REQ-011 Storage SHALL be 8 entries x 3 bits, indexed by address.
REQ-012 FSM states SHALL be CLEAR and READY; any undefined encoding SHALL go to CLEAR.
REQ-013 In CLEAR, one entry per cycle SHALL be written to 0, in order from pointer 0 to pointer 7.
REQ-014 After entry 7 is cleared, the state SHALL go to READY; busy SHALL be 1 throughout CLEAR and 0 from the first READY cycle.
REQ-015 A sweep SHALL take exactly 8 clock edges.
REQ-016 In READY, clear_req=1 SHALL enter CLEAR with the pointer at 0.
REQ-017 clear_req in READY SHALL take priority over a concurrent wren: that write is dropped and wr_ack stays 0.
REQ-018 clear_req asserted during CLEAR SHALL be ignored; the sweep is not restarted.
REQ-019 Write acceptance: wren=1 in READY, with no clear_req, SHALL store level_in at address on that edge.
REQ-020 Write clamp: a level_in of 7 SHALL be stored as 6 (maximum level); values 0..6 SHALL be stored unchanged.
REQ-021 wr_ack SHALL be 1 for exactly the cycle after each accepted write and 0 otherwise.
REQ-022 A write held high on consecutive edges SHALL be accepted and acknowledged on every edge.
REQ-023 wren during CLEAR SHALL be ignored: no storage change and no wr_ack.
REQ-024 Read path: address sampled at edge k SHALL appear on level_out at edge k+2 (2-cycle latency), continuously and with no read strobe.
REQ-025 Read coherency: level_out at edge k+2 SHALL reflect every write committed at edges up to and including k+1, with bypass for a same-address write at k+1.
REQ-026 A read and a write to the same address on the same edge SHALL return the newly written (clamped) value.
REQ-027 A read whose level_out update falls during CLEAR, or whose stage-2 edge is the CLEAR entry edge, SHALL return 0.
REQ-028 An entry that has never been written since the last clear SHALL read 0, which the level controller treats as a new user.

Reset
REQ-029 rst=0 SHALL, asynchronously: set the state to CLEAR and the pointer to 0; set level_out, wr_ack and the read pipeline registers to 0; set busy to 1.
REQ-030 On the first edge after rst is released, the sweep SHALL start at entry 0.
REQ-031 Reset asserted in the middle of a sweep or a write SHALL abort it; no partial state SHALL remain visible after the new sweep.

Verification
REQ-032 Reset, then release -> busy=1 for 8 edges, then 0; every address reads 0.
REQ-033 READY, write address=3, level_in=4 -> wr_ack pulses once; read address 3 -> level_out=4 two edges after the address is sampled.
REQ-034 Write address=5 with level_in=7 -> entry 5 reads 6.
REQ-035 Read address 2 at edge k, then write address 2 with 5 at edge k+1 -> level_out=5 at edge k+2 (bypass).
REQ-036 clear_req and wren (address 1, value 3) on the same edge -> no wr_ack, busy=1 for 8 edges, then address 1 reads 0.
REQ-037 Assert rst in the middle of a sweep at pointer 4 -> outputs are 0 immediately; after release, a full 8-edge sweep runs from 0.

Source files
------------

// File: rtl/level_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | level_store: 8 x 3-bit per-user level memory with sweep clear, write clamp |
// | and a 2-cycle coherent read pipeline.              Revision: 1.0           |
// +----------------------------------------------------------------------------+
module level_store (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] address,
  input  logic [2:0] level_in,
  input  logic       wren,
  input  logic       clear_req,
  output logic [2:0] level_out,
  output logic       wr_ack,
  output logic       busy
);

  localparam logic [1:0] c_ST_CLEAR  = 2'b01;
  localparam logic [1:0] c_ST_READY  = 2'b10;
  localparam logic [2:0] c_LAST_PTR  = 3'd7;
  localparam logic [2:0] c_LVL_RAW7  = 3'd7;
  localparam logic [2:0] c_LVL_MAX   = 3'd6;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;

  logic [2:0] r_mem [8];
  logic [2:0] r_rd_addr;
  logic [2:0] r_rd_data;

  logic       w_sweep;
  logic       w_ready;
  logic       w_wr_accept;
  logic       w_rd_kill;
  logic [2:0] w_wr_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_CLEAR;
      r_ptr   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // The pointer wraps 7 -> 0 on the last sweep edge, leaving it ready for the next clear.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      c_ST_CLEAR: begin
        w_ptr_nxt = r_ptr + 3'd1;
        if (r_ptr == c_LAST_PTR) begin
          w_state_nxt = c_ST_READY;
        end
      end
      c_ST_READY: begin
        if (clear_req) begin
          w_state_nxt = c_ST_CLEAR;
          w_ptr_nxt   = 3'd0;
        end
      end
      default: begin
        w_state_nxt = c_ST_CLEAR;
        w_ptr_nxt   = 3'd0;
      end
    endcase
  end

  always_comb begin
    w_sweep     = (r_state == c_ST_CLEAR);
    w_ready     = (r_state == c_ST_READY);
    busy        = !w_ready;
    w_wr_accept = w_ready && wren && !clear_req;
    w_rd_kill   = !w_ready || clear_req;
  end

  assign w_wr_level = (level_in == c_LVL_RAW7) ? c_LVL_MAX : level_in;

  // Storage carries no reset: every path out of reset runs a full sweep first.
  always_ff @(posedge clk) begin
    if (w_sweep) begin
      r_mem[r_ptr] <= 3'd0;
    end else if (w_wr_accept) begin
      r_mem[address] <= w_wr_level;
    end
  end

  // Stage 2 forwards a same-edge write so the result reflects every commit up to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr <= 3'd0;
      r_rd_data <= 3'd0;
      level_out <= 3'd0;
      wr_ack    <= 1'b0;
    end else begin
      r_rd_addr <= address;
      if (w_rd_kill) begin
        r_rd_data <= 3'd0;
      end else if (w_wr_accept && (address == r_rd_addr)) begin
        r_rd_data <= w_wr_level;
      end else begin
        r_rd_data <= r_mem[r_rd_addr];
      end
      level_out <= w_ready ? r_rd_data : 3'd0;
      wr_ack    <= w_wr_accept;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_level_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_level_store: table vectors plus sweep/reset sequences, level_out scored |
// | against a behavioural memory model.                Revision: 1.0           |
// +----------------------------------------------------------------------------+
module tb_level_store;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] address;
  logic [2:0] level_in;
  logic       wren;
  logic       clear_req;
  logic [2:0] level_out;
  logic       wr_ack;
  logic       busy;

  always #5 clk = ~clk;

  level_store dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .level_in  (level_in),
    .wren      (wren),
    .clear_req (clear_req),
    .level_out (level_out),
    .wr_ack    (wr_ack),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] m_mem [8];
  bit         m_ready;
  logic [2:0] m_ptr;
  logic [2:0] m_prev;
  logic [2:0] sb_q [$];

  typedef struct {
    logic [2:0] a;
    logic [2:0] l;
    bit         w;
    bit         c;
    bit         ack;
    bit         bsy;
    logic [2:0] out;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_ptr   = 3'd0;
    m_prev  = 3'd0;
    sb_q.delete();
    sb_q.push_back(3'd0);
  endtask

  // One clock: drive, advance the model across the edge, then compare just after it.
  task automatic step(input logic [2:0] a, input logic [2:0] l, input bit w, input bit c,
                      input string tag);
    bit         ready_before;
    bit         acc;
    logic [2:0] val;
    logic [2:0] exp_out;
    address      = a;
    level_in     = l;
    wren         = w;
    clear_req    = c;
    ready_before = m_ready;
    acc          = 1'b0;
    if (!m_ready) begin
      m_mem[m_ptr] = 3'd0;
      if (m_ptr == 3'd7) m_ready = 1'b1;
      m_ptr++;
    end else if (c) begin
      m_ready = 1'b0;
      m_ptr   = 3'd0;
    end else if (w) begin
      m_mem[a] = (l == 3'd7) ? 3'd6 : l;
      acc      = 1'b1;
    end
    // The read sampled one edge ago sees memory after this edge's commit; clears read 0.
    val    = (ready_before && m_ready) ? m_mem[m_prev] : 3'd0;
    m_prev = a;
    sb_q.push_back(val);
    @(posedge clk);
    #1;
    exp_out = sb_q.pop_front();
    check({tag, ".level_out"}, level_out, exp_out);
    check({tag, ".wr_ack"}, wr_ack, acc);
    check({tag, ".busy"}, busy, !m_ready);
  endtask

  task automatic wait_sweep(input string tag, input logic [2:0] a, input logic [2:0] l,
                            input bit w, input bit c);
    int  n    = 0;
    bit  done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(a, l, w, c, tag);
      n++;
      if (busy === 1'b0) done = 1'b1;
    end
    check({tag, ".sweep_edges"}, n, 8);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 8; i++) step(i[2:0], 3'd0, 1'b0, 1'b0, tag);
    step(3'd0, 3'd0, 1'b0, 1'b0, tag);
    step(3'd0, 3'd0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    //            a     l     w  c  ack bsy out
    tbl[0]  = '{3'd3, 3'd4, 1, 0, 1, 0, 3'd0};
    tbl[1]  = '{3'd3, 3'd0, 0, 0, 0, 0, 3'd0};
    tbl[2]  = '{3'd3, 3'd0, 0, 0, 0, 0, 3'd4};
    tbl[3]  = '{3'd5, 3'd7, 1, 0, 1, 0, 3'd4};
    tbl[4]  = '{3'd5, 3'd0, 0, 0, 0, 0, 3'd4};
    tbl[5]  = '{3'd5, 3'd0, 0, 0, 0, 0, 3'd6};
    tbl[6]  = '{3'd0, 3'd0, 0, 0, 0, 0, 3'd6};
    tbl[7]  = '{3'd2, 3'd0, 0, 0, 0, 0, 3'd6};
    tbl[8]  = '{3'd2, 3'd5, 1, 0, 1, 0, 3'd0};
    tbl[9]  = '{3'd2, 3'd0, 0, 0, 0, 0, 3'd5};
    tbl[10] = '{3'd0, 3'd0, 0, 0, 0, 0, 3'd5};
    tbl[11] = '{3'd6, 3'd2, 1, 0, 1, 0, 3'd5};
    tbl[12] = '{3'd7, 3'd3, 1, 0, 1, 0, 3'd0};
    tbl[13] = '{3'd6, 3'd0, 0, 0, 0, 0, 3'd2};
    tbl[14] = '{3'd7, 3'd0, 0, 0, 0, 0, 3'd3};
    tbl[15] = '{3'd0, 3'd0, 0, 0, 0, 0, 3'd2};
    tbl[16] = '{3'd4, 3'd1, 1, 0, 1, 0, 3'd3};
    tbl[17] = '{3'd0, 3'd0, 0, 0, 0, 0, 3'd0};
    tbl[18] = '{3'd0, 3'd0, 0, 0, 0, 0, 3'd1};

    for (int i = 0; i < 8; i++) m_mem[i] = 3'd0;
    rst       = 1'b0;
    address   = 3'd0;
    level_in  = 3'd0;
    wren      = 1'b0;
    clear_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.level_out", level_out, 0);
    check("reset.wr_ack", wr_ack, 0);
    check("reset.busy", busy, 1);
    rst = 1'b1;

    wait_sweep("init_sweep", 3'd0, 3'd0, 1'b0, 1'b0);
    read_all("init_read");

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].a, tbl[i].l, tbl[i].w, tbl[i].c, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.vec_out", i), level_out, tbl[i].out);
      check($sformatf("tbl%0d.vec_ack", i), wr_ack, tbl[i].ack);
      check($sformatf("tbl%0d.vec_busy", i), busy, tbl[i].bsy);
    end

    // Clear request beats a same-edge write; writes and repeat clears during the sweep are ignored.
    step(3'd1, 3'd2, 1'b1, 1'b0, "pre_clear_wr");
    step(3'd1, 3'd3, 1'b1, 1'b1, "clear_vs_wr");
    check("clear_vs_wr.no_ack", wr_ack, 0);
    wait_sweep("clear_sweep", 3'd1, 3'd5, 1'b1, 1'b1);
    read_all("post_clear_read");

    // Reset while a write is being acknowledged and data is on level_out.
    step(3'd2, 3'd5, 1'b1, 1'b0, "d1_wr");
    step(3'd2, 3'd5, 1'b1, 1'b0, "d1_wr");
    step(3'd2, 3'd5, 1'b1, 1'b0, "d1_wr");
    check("d1.pre_level_out", level_out, 5);
    rst = 1'b0;
    #2;
    check("d1_rst.level_out", level_out, 0);
    check("d1_rst.wr_ack", wr_ack, 0);
    check("d1_rst.busy", busy, 1);
    rst = 1'b1;
    model_reset();
    wait_sweep("d1_sweep", 3'd0, 3'd0, 1'b0, 1'b0);
    step(3'd2, 3'd0, 1'b0, 1'b0, "d1_read");
    step(3'd0, 3'd0, 1'b0, 1'b0, "d1_read");
    step(3'd0, 3'd0, 1'b0, 1'b0, "d1_read");
    check("d1_read.addr2_zero", level_out, 0);

    // Reset in the middle of a sweep, with the pointer at 4.
    step(3'd0, 3'd3, 1'b1, 1'b0, "d2_wr");
    step(3'd0, 3'd0, 1'b0, 1'b1, "d2_clear");
    repeat (4) step(3'd0, 3'd0, 1'b0, 1'b0, "d2_partial");
    rst = 1'b0;
    #2;
    check("d2_rst.level_out", level_out, 0);
    check("d2_rst.wr_ack", wr_ack, 0);
    check("d2_rst.busy", busy, 1);
    rst = 1'b1;
    model_reset();
    wait_sweep("d2_sweep", 3'd0, 3'd0, 1'b0, 1'b0);
    read_all("d2_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
